// File: rtl/stepper_phase_sequencer_pkg.sv
// stepper_phase_sequencer_pkg: shared mode encodings, half-step coil table and index stepping helper
package stepper_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE = 2'b00,
        MODE_FULL = 2'b01,
        MODE_HALF = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Entry i is the coil pattern for half-step index i (index 7 first in the concatenation)
    localparam logic [7:0][3:0] HALF_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    localparam logic [2:0] RESET_IDX = 3'd1;

    // Wave wants even indices, full-step (and the reserved code) odd ones; a wrong-parity
    // index moves by one to realign, otherwise two. Half-step always moves by one.
    function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir, input logic [1:0] mode);
        logic [2:0] d;
        d = (mode == MODE_HALF) ? 3'd1 : ((idx[0] == (mode != MODE_WAVE)) ? 3'd2 : 3'd1);
        return dir ? idx + d : idx - d;
    endfunction

endpackage

// File: rtl/stepper_phase_sequencer_if.sv
// stepper_phase_sequencer_if: control inputs and coil/position outputs between motion logic and the sequencer
interface stepper_phase_sequencer_if #(
    parameter int DIV_WIDTH = 16,
    parameter int POS_WIDTH = 16
);
    logic                 i_en;
    logic                 i_dir;
    logic [1:0]           i_mode;
    logic [DIV_WIDTH-1:0] i_step_div;
    logic                 i_step_req;
    logic                 i_pos_clr;
    logic [3:0]           o_coils;
    logic [2:0]           o_phase_idx;
    logic [POS_WIDTH-1:0] o_position;
    logic                 o_step_pulse;

    modport master (
        output i_en, i_dir, i_mode, i_step_div, i_step_req, i_pos_clr,
        input  o_coils, o_phase_idx, o_position, o_step_pulse
    );

    modport slave (
        input  i_en, i_dir, i_mode, i_step_div, i_step_req, i_pos_clr,
        output o_coils, o_phase_idx, o_position, o_step_pulse
    );
endinterface

// File: rtl/stepper_phase_sequencer_step_rate_prescaler.sv
// step_rate_prescaler: free-running divider that ticks once every i_step_div+1 enabled cycles
module step_rate_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_step_div,
    output logic                 o_tick
);
    logic [DIV_WIDTH-1:0] r_count;
    logic                 w_run;

    assign w_run  = i_en && (i_step_div != '0);
    // >= rather than == so a divider lowered below the running count still ticks promptly
    assign o_tick = w_run && (r_count >= i_step_div);

    // Count while running, restart on tick, park at zero when stopped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_count <= '0;
        else      r_count <= (!w_run || o_tick) ? '0 : r_count + DIV_WIDTH'(1);
    end
endmodule

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: wave/full/half-step coil sequencer with rate prescaler and signed position
module stepper_phase_sequencer
    import stepper_phase_sequencer_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int POS_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    stepper_phase_sequencer_if.slave  bus
);
    logic                 w_tick;
    logic                 w_step;
    logic [2:0]           w_next_idx;
    logic [POS_WIDTH-1:0] w_delta;
    logic [2:0]           r_idx;
    logic [3:0]           r_coils;
    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_pulse;

    step_rate_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_en       (bus.i_en),
        .i_step_div (bus.i_step_div),
        .o_tick     (w_tick)
    );

    // A tick and a request in the same cycle merge into one step
    assign w_step     = bus.i_en && (w_tick || bus.i_step_req);
    assign w_next_idx = w_step ? next_idx(r_idx, bus.i_dir, bus.i_mode) : r_idx;
    assign w_delta    = bus.i_dir ? POS_WIDTH'(1) : '1;

    // Phase, coil pattern, position and step strobe all update together on a step;
    // coils go dark while disabled but the phase index is kept for re-enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= RESET_IDX;
            r_coils <= 4'b0000;
            r_pos   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_idx   <= w_next_idx;
            r_coils <= bus.i_en ? HALF_TABLE[w_next_idx] : 4'b0000;
            r_pos   <= bus.i_pos_clr ? '0 : (w_step ? r_pos + w_delta : r_pos);
            r_pulse <= w_step;
        end
    end

    assign bus.o_coils      = r_coils;
    assign bus.o_phase_idx  = r_idx;
    assign bus.o_position   = r_pos;
    assign bus.o_step_pulse = r_pulse;
endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: scoreboard bench with a behavioural stepping model and randomized stimulus
module tb_stepper_phase_sequencer;
    localparam int DW = 16;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stepper_phase_sequencer_if #(.DIV_WIDTH(DW), .POS_WIDTH(PW)) bus ();

    stepper_phase_sequencer #(.DIV_WIDTH(DW), .POS_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]    coils;
        logic [2:0]    idx;
        logic [PW-1:0] pos;
        logic          pulse;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model state: half-step index, unbounded position, cycles counted since the rate clock started
    int m_idx = 1;
    int m_pos = 0;
    int m_cnt = 0;
    bit [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_coils"}, 32'(bus.o_coils), 32'd0);
        check({tag, "_idx"}, 32'(bus.o_phase_idx), 32'd1);
        check({tag, "_pos"}, 32'(bus.o_position), 32'd0);
        check({tag, "_pulse"}, 32'(bus.o_step_pulse), 32'd0);
    endtask

    // Drive one cycle of inputs and predict what the next rising edge must show
    task automatic apply(input bit en, input bit dir, input bit [1:0] mode, input int div, input bit req, input bit clr);
        bit tick, step;
        int d;
        exp_t e;
        bus.i_en       = en;
        bus.i_dir      = dir;
        bus.i_mode     = mode;
        bus.i_step_div = DW'(div);
        bus.i_step_req = req;
        bus.i_pos_clr  = clr;
        tick  = en && div != 0 && m_cnt >= div;
        m_cnt = (en && div != 0 && !tick) ? m_cnt + 1 : 0;
        step  = en && (tick || req);
        if (step) begin
            if (mode == 2'b10) d = 1;
            else d = (((m_idx % 2) == 1) == (mode != 2'b00)) ? 2 : 1;
            m_idx = dir ? (m_idx + d) % 8 : (m_idx + 8 - d) % 8;
            m_pos += dir ? 1 : -1;
        end
        if (clr) m_pos = 0;
        e.coils = en ? tbl[m_idx] : 4'b0000;
        e.idx   = 3'(m_idx);
        e.pos   = PW'(m_pos);
        e.pulse = step;
        q.push_back(e);
    endtask

    task automatic cyc(input bit en, input bit dir, input bit [1:0] mode, input int div, input bit req, input bit clr);
        @(negedge clk);
        apply(en, dir, mode, div, req, clr);
    endtask

    // Asynchronous reset dropped between edges while stepping, then released on a falling edge
    task automatic mid_reset;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        reset_check("midrst");
        m_idx = 1;
        m_pos = 0;
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_check("midrst_hold");
        rst = 1'b1;
        apply(1, 1, 2'b01, 0, 1, 0);
    endtask

    // Monitor: every edge out of reset must match the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("coils", 32'(bus.o_coils), 32'(e.coils));
                    check("phase_idx", 32'(bus.o_phase_idx), 32'(e.idx));
                    check("position", 32'(bus.o_position), 32'(e.pos));
                    check("step_pulse", 32'(bus.o_step_pulse), 32'(e.pulse));
                end
            end
        end
    end

    initial begin
        bit r_dir;
        bit [1:0] r_mode;
        int r_div;
        bus.i_en = 1'b0;
        bus.i_dir = 1'b0;
        bus.i_mode = 2'b00;
        bus.i_step_div = '0;
        bus.i_step_req = 1'b0;
        bus.i_pos_clr = 1'b0;
        #12;
        reset_check("por");
        @(negedge clk);
        rst = 1'b1;
        apply(1, 1, 2'b01, 3, 0, 0);
        repeat (20) cyc(1, 1, 2'b01, 3, 0, 0);
        mid_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 2'b10, 0, 1, 0);
            cyc(1, 0, 2'b10, 0, 0, 0);
        end
        cyc(1, 1, 2'b01, 0, 1, 0);
        repeat (3) begin
            cyc(1, 1, 2'b00, 0, 1, 0);
            cyc(1, 1, 2'b00, 0, 0, 0);
        end
        repeat (2) cyc(1, 0, 2'b10, 0, 0, 0);
        repeat (7) cyc(1, 1, 2'b01, 5, 0, 0);
        repeat (3) cyc(0, 1, 2'b01, 5, 1, 0);
        repeat (10) cyc(1, 1, 2'b01, 5, 0, 0);
        repeat (12) cyc(1, 0, 2'b01, 3, 1'($urandom % 2), 0);
        cyc(1, 1, 2'b10, 0, 1, 1);
        cyc(1, 1, 2'b10, 0, 0, 0);
        repeat (6) cyc(1, 1, 2'b01, 9, 0, 0);
        repeat (3) cyc(1, 1, 2'b01, 1, 0, 0);
        mid_reset();
        repeat (4) cyc(1, 1, 2'b10, 0, 1, 0);
        r_dir = 1'b1;
        r_mode = 2'b01;
        r_div = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) r_dir = 1'($urandom);
            if ($urandom_range(0, 19) == 0) r_mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) r_div = $urandom_range(0, 6);
            cyc($urandom_range(0, 9) != 0, r_dir, r_mode, r_div,
                $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
            if (i == 700) mid_reset();
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stepper_phase_sequencer.md
Name: stepper_phase_sequencer

Overview:
Parametrised coil-phase sequencer for 4-coil unipolar/bipolar stepper drivers, generalising the fixed 4-state full-step ring counter. It supports three modes (wave, full-step and half-step) and both directions. Steps come from a programmable rate prescaler or single-step requests. It also tracks signed position. The block sits between motion-control logic and the coil driver pins.

Parameters:
DIV_WIDTH, 16, width of step-rate divider and prescaler counter
POS_WIDTH, 16, width of signed position counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
en  input  1  1 = coils energised and stepping allowed; 0 = coils off, stepping frozen
dir  input  1  1 = forward (index increments), 0 = reverse
mode  input  2  00 wave, 01 full-step, 10 half-step, 11 treated as full-step
step_div  input  DIV_WIDTH  free-run period minus 1; 0 = free-run off
step_req  input  1  single-step request, one step per high cycle
pos_clr  input  1  synchronous clear of position
coils  output  4  coil drive pattern, registered
phase_idx  output  3  current half-step table index
position  output  POS_WIDTH  signed step count, two's complement
step_pulse  output  1  one-cycle strobe coincident with each coils update from a step

Behaviour:
- Half-step table H[0..7] = 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Wave mode uses even indices: 0001, 0010, 0100, 1000.
- Full-step mode uses odd indices: 0011, 0110, 1100, 1001.
- Half-step mode uses all 8 indices.
- Reset (rst=0, async) sets: phase_idx=1, coils=0000, position=0, step_pulse=0, prescaler count=0.
- Prescaler:
  - When en=1 and step_div!=0, the count increments each cycle.
  - When count >= step_div, a tick fires and the count returns to 0, giving one tick every step_div+1 cycles.
  - Lowering step_div below the current count forces a tick on the next cycle.
  - When en=0 or step_div=0, the count is held at 0 and there is no tick.
- A step event occurs when en=1 and (tick or step_req). A tick and a step_req in the same cycle produce exactly one step.
- Step arithmetic is mod 8, with dir=1 adding and dir=0 subtracting:
  - Half-step: delta ±1.
  - Wave or full-step with correct index parity: delta ±2.
  - Wave or full-step with wrong parity (after a mode change): delta ±1, which realigns the index, then ±2 afterwards.
  - Wrap-around: 7 -> 0 forward, 0 -> 7 reverse.
- Latency: a step event in cycle N updates phase_idx, position and step_pulse at edge N+1. coils follow at the same edge.
- coils register: loads H[next phase_idx] when en=1, loads 0000 when en=0. phase_idx is retained while disabled.
- Re-enabling restores H[phase_idx] one cycle after en rises, with no step taken.
- Mode change alone does not step. coils show H[phase_idx] unchanged until the next step.
- position changes by +1/-1 per step event and wraps in two's complement.
- pos_clr=1 gives position=0 next edge. This takes priority over a simultaneous step, although phase still advances.
- dir and mode are sampled only in the step cycle; changes between steps have no effect until then.
- Reset mid-operation returns immediately to the reset values regardless of clk.

Decomposition:
- Shared package holds:
  - mode encodings: MODE_WAVE, MODE_FULL, MODE_HALF
  - the 8-entry half-step table constant
  - the reset index constant (1)
- One natural sub-module, step_rate_prescaler, contains the divider counter and tick generation. The top level contains the index/parity logic, coil register and position counter.

Test Plan:
1. Reset, en=1, mode=01, dir=1, step_div=3 -> coils 0011 until first tick, then 0110, 1100, 1001, 0011 every 4 cycles; position 1, 2, 3, 4; step_pulse one cycle each.
2. mode=10, dir=0, step_div=0, eight step_req pulses from idx 1 -> coils 0001, 1001, 1000, 1100, 0100, 0110, 0010, 0011; position -8.
3. Full-step at idx 3, switch to mode=00, dir=1, step_req -> idx 4 (0100), next step idx 6 (1000), then wraps to idx 0 (0001).
4. Free-run with en dropped mid-count -> coils 0000 next cycle, no step_pulse, phase_idx held. en restored -> previous pattern returns with the prescaler restarted from 0.
5. step_req coincident with tick -> single step (delta 2 in full-step). pos_clr with step -> position 0, phase advances.
6. rst asserted between clock edges during stepping -> outputs immediately coils 0000, phase_idx 1, position 0. After release, first step from idx 1.
